// File: rtl/ctrl_cell_pkg.sv
// Constants and helpers shared between the cell array and its parameter dispatcher.
package ctrl_cell_pkg;
  localparam int CELL_MSB    = 31;
  localparam int CELL_ADDR_W = 3;

  typedef enum logic {ST_EMPTY, ST_HEAD} issue_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/param_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered occupancy count.
module param_fifo import ctrl_cell_pkg::*; #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk)
    if (wr_en) mem[wp[AW-1:0]] <= wr_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
endmodule

// File: rtl/cell_param_dispatch.sv
// Queues host parameter writes and strobes them into cells, deferring while the
// target cell has data arriving (param_en would otherwise drop that sample).
module cell_param_dispatch import ctrl_cell_pkg::*; #(
  parameter int MSB        = CELL_MSB,
  parameter int N_CELLS    = 8,
  parameter int ADDR_W     = CELL_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DEFER  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [MSB:0]               wr_data,
  input  logic [N_CELLS-1:0]         data_en_next,
  output logic [MSB:0]               param_out,
  output logic [N_CELLS-1:0]         param_en,
  output logic                       forced,
  output logic                       err_bad_addr,
  input  logic                       err_clr,
  output logic [clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int DW = (MAX_DEFER < 1) ? 1 : clog2(MAX_DEFER + 1);
  localparam int EW = ADDR_W + MSB + 1;

  issue_st_e          st;
  logic [DW-1:0]      defer;
  logic [EW-1:0]      head;
  logic [ADDR_W-1:0]  head_addr;
  logic [MSB:0]       head_data;
  logic [N_CELLS-1:0] sel;
  logic               xfer, bad, push, blk, issue;

  // wr_ready looks only at the registered count; full means count == DEPTH.
  assign wr_ready  = !fifo_count[AW];
  assign xfer      = wr_valid && wr_ready;
  assign bad       = int'(wr_addr) >= N_CELLS;
  assign push      = xfer && !bad;
  assign {head_addr, head_data} = head;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_CELLS; i++) sel[i] = (int'(head_addr) == i);
  end

  assign blk   = |(data_en_next & sel);
  assign issue = (st == ST_HEAD) && (!blk || defer == DW'(MAX_DEFER));

  param_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({wr_addr, wr_data}),
    .rd_en   (issue),
    .rd_data (head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st           <= ST_EMPTY;
      defer        <= '0;
      param_en     <= '0;
      param_out    <= '0;
      forced       <= 1'b0;
      err_bad_addr <= 1'b0;
    end else begin
      param_en <= '0;
      forced   <= 1'b0;
      // A new bad write outranks a coincident clear.
      if (xfer && bad)  err_bad_addr <= 1'b1;
      else if (err_clr) err_bad_addr <= 1'b0;
      case (st)
        ST_EMPTY: begin
          defer <= '0;
          if (push) st <= ST_HEAD;
        end
        ST_HEAD: begin
          if (issue) begin
            param_en  <= sel;
            param_out <= head_data;
            forced    <= blk;
            defer     <= '0;
            if (fifo_count == {{AW{1'b0}}, 1'b1} && !push) st <= ST_EMPTY;
          end else begin
            defer <= defer + 1'b1;
          end
        end
        default: st <= ST_EMPTY;
      endcase
    end
endmodule

// File: tb/tb_cell_param_dispatch.sv
// Scenario bench for cell_param_dispatch: scoreboard of expected issues checked by a pulse monitor.
module tb_cell_param_dispatch;
  localparam int NC = 6;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic        forced;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [NC-1:0] data_en_next = '0;
  logic [31:0]   param_out;
  logic [NC-1:0] param_en;
  logic          forced;
  logic          err_bad_addr;
  logic          err_clr = 1'b0;
  logic [2:0]    fifo_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pulse_cyc[$];
  exp_t me;
  logic [NC-1:0] me_en;

  cell_param_dispatch #(.MSB(31), .N_CELLS(NC), .ADDR_W(3), .FIFO_DEPTH(4), .MAX_DEFER(15)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .data_en_next(data_en_next), .param_out(param_out), .param_en(param_en),
    .forced(forced), .err_bad_addr(err_bad_addr), .err_clr(err_clr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest outstanding write.
  always @(negedge clk)
    if (!rst && param_en !== '0) begin
      pulse_cyc.push_back(cyc);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue got en=%b data=%h, expected no issue", param_en, param_out);
      end else begin
        me    = sb.pop_front();
        me_en = NC'(1) << me.addr;
        if (param_en !== me_en || param_out !== me.data || forced !== me.forced) begin
          bad++;
          $display("FAIL issue_order got en=%b data=%h forced=%b want en=%b data=%h forced=%b",
                   param_en, param_out, forced, me_en, me.data, me.forced);
        end
      end
    end

  // Presents a write at a negedge, waits for ready, returns at the negedge after transfer.
  task automatic push_write(input logic [2:0] a, input logic [31:0] d, input logic f);
    int n;
    exp_t e;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      total++; bad++;
      $display("FAIL write_timeout wr_ready=%b required 1", wr_ready);
      return;
    end
    if (int'(a) < NC) begin
      e.addr = a; e.data = d; e.forced = f;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    wr_valid = 1'b0;
    repeat (n) @(negedge clk);
    total++;
    if (sb.size() != 0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL drain outstanding=%0d fifo_count=%0d required 0/0", sb.size(), fifo_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (param_en !== '0 || param_out !== '0 || forced !== 1'b0 || err_bad_addr !== 1'b0 ||
        fifo_count !== 3'd0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state en=%b out=%h forced=%b err=%b cnt=%0d rdy=%b required all 0, rdy=1",
               param_en, param_out, forced, err_bad_addr, fifo_count, wr_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    push_write(3'd2, 32'h1234, 1'b0);
    wr_valid = 1'b0;
    total++;
    if (param_en !== '0) begin bad++; $display("FAIL lat_early en=%b required 0", param_en); end
    @(negedge clk);
    total++;
    if (param_en !== 6'b000100 || param_out !== 32'h1234 || forced !== 1'b0) begin
      bad++;
      $display("FAIL lat_issue en=%b out=%h forced=%b required 000100/1234/0", param_en, param_out, forced);
    end
    @(negedge clk);
    total++;
    if (param_en !== '0 || param_out !== 32'h1234) begin
      bad++;
      $display("FAIL lat_drop en=%b out=%h required 0 and held 1234", param_en, param_out);
    end
    drain(3);
  endtask

  task automatic test_defer();
    int seen;
    data_en_next = 6'b100000;
    push_write(3'd5, 32'hAA, 1'b1);
    wr_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (param_en !== '0) begin seen = k; break; end
    end
    total++;
    if (seen != 16 || forced !== 1'b1) begin
      bad++;
      $display("FAIL defer_forced cycles=%0d forced=%b required 16/1", seen, forced);
    end
    data_en_next = '0;
    drain(3);
    data_en_next = 6'b100000;
    push_write(3'd5, 32'hBB, 1'b0);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (param_en !== '0) begin bad++; $display("FAIL defer_hold en=%b required 0", param_en); end
    data_en_next = '0;
    @(negedge clk);
    total++;
    if (param_en !== 6'b100000 || forced !== 1'b0 || param_out !== 32'hBB) begin
      bad++;
      $display("FAIL defer_release en=%b forced=%b out=%h required 100000/0/bb", param_en, forced, param_out);
    end
    drain(3);
  endtask

  task automatic test_full();
    data_en_next = '1;
    for (int i = 0; i < 4; i++) push_write(3'(i), 32'hC0 + i, 1'b0);
    wr_addr = 3'd4;
    wr_data = 32'hC4;
    total++;
    if (wr_ready !== 1'b0 || fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL full_ready rdy=%b cnt=%0d required 0/4", wr_ready, fifo_count);
    end
    repeat (6) @(negedge clk);
    total++;
    if (wr_ready !== 1'b0 || param_en !== '0) begin
      bad++;
      $display("FAIL full_hold rdy=%b en=%b required 0/0", wr_ready, param_en);
    end
    data_en_next = '0;
    push_write(3'd4, 32'hC4, 1'b0);
    push_write(3'd5, 32'hC5, 1'b0);
    drain(12);
  endtask

  task automatic test_bad_addr();
    push_write(3'd7, 32'hDEAD, 1'b0);
    wr_valid = 1'b0;
    total++;
    if (err_bad_addr !== 1'b1 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL bad_addr_set err=%b cnt=%0d required 1/0", err_bad_addr, fifo_count);
    end
    err_clr = 1'b1;
    push_write(3'd6, 32'hBEEF, 1'b0);
    wr_valid = 1'b0;
    total++;
    if (err_bad_addr !== 1'b1) begin
      bad++;
      $display("FAIL bad_addr_set_wins err=%b required 1", err_bad_addr);
    end
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (err_bad_addr !== 1'b0) begin
      bad++;
      $display("FAIL bad_addr_clr err=%b required 0", err_bad_addr);
    end
    drain(3);
  endtask

  task automatic test_reset_mid();
    push_write(3'd1, 32'h11, 1'b0);
    push_write(3'd2, 32'h22, 1'b0);
    push_write(3'd3, 32'h33, 1'b0);
    wr_valid = 1'b0;
    #1 rst = 1'b1;
    sb.delete();
    #1;
    total++;
    if (param_en !== '0 || param_out !== '0 || forced !== 1'b0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid en=%b out=%h forced=%b cnt=%0d required 0", param_en, param_out, forced, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_cyc.delete();
    repeat (6) @(negedge clk);
    total++;
    if (pulse_cyc.size() != 0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_no_issue pulses=%0d cnt=%0d required 0/0", pulse_cyc.size(), fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    pulse_cyc.delete();
    push_write(3'd0, 32'hA0, 1'b0);
    push_write(3'd1, 32'hA1, 1'b0);
    push_write(3'd2, 32'hA2, 1'b0);
    drain(4);
    total++;
    if (pulse_cyc.size() != 3 || pulse_cyc[1] != pulse_cyc[0] + 1 || pulse_cyc[2] != pulse_cyc[1] + 1) begin
      bad++;
      $display("FAIL b2b_consecutive pulses=%0d required 3 on consecutive cycles", pulse_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_defer();
    test_full();
    test_bad_addr();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
